// File: rtl/pattern_scan_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : pattern_scan_arbiter
//  Purpose  : Round-robin sharing of one combinational pattern detector
//             between N_REQ word producers. A granted word is registered onto
//             the detector input and given one settle cycle. The count is then
//             captured, tagged with the requester ID, and added to a
//             saturating running total.
//  Revision : 1.0 - initial release
// ============================================================================
module pattern_scan_arbiter #(
  parameter  int N_REQ = 2,
  parameter  int DW    = 32,
  parameter  int CW    = 4,
  parameter  int ACC_W = 16,
  localparam int IDW   = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    req_ready,
  output logic [DW-1:0]       det_din,
  input  logic [CW-1:0]       det_count,
  output logic                rsp_valid,
  output logic [IDW-1:0]      rsp_id,
  output logic [CW-1:0]       rsp_count,
  input  logic                acc_clear,
  output logic [ACC_W-1:0]    acc_total,
  output logic                acc_sat
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t           state_q,     state_d;
  logic [IDW-1:0]   rr_ptr_q,    rr_ptr_d;
  logic [IDW-1:0]   gnt_id_q,    gnt_id_d;
  logic [DW-1:0]    det_din_q,   det_din_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q,    rsp_id_d;
  logic [CW-1:0]    rsp_count_q, rsp_count_d;
  logic [ACC_W-1:0] acc_total_q, acc_total_d;
  logic             acc_sat_q,   acc_sat_d;

  logic             gnt_found;
  logic [IDW-1:0]   gnt_idx;
  logic [IDW-1:0]   gnt_next_ptr;
  logic [IDW:0]     cand;
  logic [ACC_W:0]   acc_sum;

  // Find the first valid requester at or above rr_ptr, wrapping at N_REQ.
  // cand has one spare bit so rr_ptr + k never overflows before the wrap.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(N_REQ)) begin
        cand = cand - (IDW+1)'(N_REQ);
      end
      if (!gnt_found && req_valid[cand[IDW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[IDW-1:0];
      end
    end
  end

  assign gnt_next_ptr = (gnt_idx == IDW'(N_REQ - 1)) ? '0 : gnt_idx + IDW'(1);
  assign acc_sum      = {1'b0, acc_total_q} + (ACC_W+1)'(det_count);

  // Grant is offered only while idle and never while reset is asserted.
  assign req_ready = (rst_n && (state_q == S_IDLE) && gnt_found)
                     ? (N_REQ'(1) << gnt_idx) : '0;

  // Next-state and next-output computation for the transaction sequencer.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_id_d    = gnt_id_q;
    det_din_d   = det_din_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_count_d = rsp_count_q;
    acc_total_d = acc_total_q;
    acc_sat_d   = acc_sat_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          state_d   = S_DRIVE;
          det_din_d = req_data[int'(gnt_idx)*DW +: DW];
          gnt_id_d  = gnt_idx;
          rr_ptr_d  = gnt_next_ptr;
        end
      end
      S_DRIVE: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b1;
        rsp_id_d    = gnt_id_q;
        rsp_count_d = det_count;
        if (acc_sat_q || acc_sum[ACC_W]) begin
          acc_total_d = '1;
          acc_sat_d   = 1'b1;
        end else begin
          acc_total_d = acc_sum[ACC_W-1:0];
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // A clear beats an accumulation landing in the same cycle.
    if (acc_clear) begin
      acc_total_d = '0;
      acc_sat_d   = 1'b0;
    end
  end

  // State and registered outputs; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      gnt_id_q    <= '0;
      det_din_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_count_q <= '0;
      acc_total_q <= '0;
      acc_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_id_q    <= gnt_id_d;
      det_din_q   <= det_din_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_count_q <= rsp_count_d;
      acc_total_q <= acc_total_d;
      acc_sat_q   <= acc_sat_d;
    end
  end

  assign det_din   = det_din_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_count = rsp_count_q;
  assign acc_total = acc_total_q;
  assign acc_sat   = acc_sat_q;

endmodule
`default_nettype wire

// File: tb/tb_pattern_scan_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pattern_scan_arbiter
//  Purpose  : Directed bench for pattern_scan_arbiter. Instance A uses the
//             default two-requester build, instance B a three-requester build
//             with a 4-bit total. Both use det_count = det_din[3:0].
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pattern_scan_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A: N_REQ=2, ACC_W=16
  logic [1:0]  req_valid_a;
  logic [63:0] req_data_a;
  logic [1:0]  req_ready_a;
  logic [31:0] det_din_a;
  logic [3:0]  det_count_a;
  logic        rsp_valid_a;
  logic [0:0]  rsp_id_a;
  logic [3:0]  rsp_count_a;
  logic        acc_clear_a;
  logic [15:0] acc_total_a;
  logic        acc_sat_a;

  // Instance B: N_REQ=3, ACC_W=4
  logic [2:0]  req_valid_b;
  logic [95:0] req_data_b;
  logic [2:0]  req_ready_b;
  logic [31:0] det_din_b;
  logic [3:0]  det_count_b;
  logic        rsp_valid_b;
  logic [1:0]  rsp_id_b;
  logic [3:0]  rsp_count_b;
  logic        acc_clear_b;
  logic [3:0]  acc_total_b;
  logic        acc_sat_b;

  assign det_count_a = det_din_a[3:0];
  assign det_count_b = det_din_b[3:0];

  pattern_scan_arbiter #(.N_REQ(2), .DW(32), .CW(4), .ACC_W(16)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_a), .req_data(req_data_a), .req_ready(req_ready_a),
    .det_din(det_din_a), .det_count(det_count_a),
    .rsp_valid(rsp_valid_a), .rsp_id(rsp_id_a), .rsp_count(rsp_count_a),
    .acc_clear(acc_clear_a), .acc_total(acc_total_a), .acc_sat(acc_sat_a)
  );

  pattern_scan_arbiter #(.N_REQ(3), .DW(32), .CW(4), .ACC_W(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_b), .req_data(req_data_b), .req_ready(req_ready_b),
    .det_din(det_din_b), .det_count(det_count_b),
    .rsp_valid(rsp_valid_b), .rsp_id(rsp_id_b), .rsp_count(rsp_count_b),
    .acc_clear(acc_clear_b), .acc_total(acc_total_b), .acc_sat(acc_sat_b)
  );

  int vectors = 0;
  int errors  = 0;

  // Reset both instances; returns on a falling edge with rst_n released.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid_a = '0; req_data_a = '0; acc_clear_a = 1'b0;
    req_valid_b = '0; req_data_b = '0; acc_clear_b = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid_a = '0; req_valid_b = '0; acc_clear_a = 1'b0; acc_clear_b = 1'b0;
    #1;
    vectors++; if (req_ready_a !== 2'b00) begin errors++; $display("FAIL reset_ready_a: got %b want 00", req_ready_a); end
    vectors++; if (det_din_a !== 32'h0) begin errors++; $display("FAIL reset_det_din_a: got %h want 0", det_din_a); end
    vectors++; if (rsp_valid_a !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid_a: got %b want 0", rsp_valid_a); end
    vectors++; if (rsp_id_a !== 1'b0 || rsp_count_a !== 4'h0) begin errors++; $display("FAIL reset_rsp_a: got id %h count %h want 0 0", rsp_id_a, rsp_count_a); end
    vectors++; if (acc_total_a !== 16'h0 || acc_sat_a !== 1'b0) begin errors++; $display("FAIL reset_acc_a: got %h/%b want 0/0", acc_total_a, acc_sat_a); end
    vectors++; if (acc_total_b !== 4'h0 || rsp_valid_b !== 1'b0 || req_ready_b !== 3'b000) begin errors++; $display("FAIL reset_b: got acc %h rsp %b ready %b want 0 0 000", acc_total_b, rsp_valid_b, req_ready_b); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Single requester: latency, single-cycle pulse, ready low while busy.
  task automatic test_single();
    do_reset();
    req_valid_a = 2'b01;
    req_data_a  = {32'h0, 32'h0000_0007};
    #1;
    vectors++; if (req_ready_a !== 2'b01) begin errors++; $display("FAIL single_ready_idle: got %b want 01", req_ready_a); end
    @(negedge clk);  // after transfer edge: DRIVE
    vectors++; if (req_ready_a !== 2'b00) begin errors++; $display("FAIL single_ready_drive: got %b want 00", req_ready_a); end
    vectors++; if (det_din_a !== 32'h7) begin errors++; $display("FAIL single_det_din: got %h want 7", det_din_a); end
    vectors++; if (rsp_valid_a !== 1'b0) begin errors++; $display("FAIL single_rsp_early_drive: got %b want 0", rsp_valid_a); end
    @(negedge clk);  // RESP
    vectors++; if (req_ready_a !== 2'b00) begin errors++; $display("FAIL single_ready_resp: got %b want 00", req_ready_a); end
    vectors++; if (rsp_valid_a !== 1'b0) begin errors++; $display("FAIL single_rsp_early_resp: got %b want 0", rsp_valid_a); end
    req_valid_a = 2'b00;
    @(negedge clk);  // after transfer edge + 2
    vectors++; if (rsp_valid_a !== 1'b1) begin errors++; $display("FAIL single_rsp_valid: got %b want 1", rsp_valid_a); end
    vectors++; if (rsp_id_a !== 1'b0 || rsp_count_a !== 4'h7) begin errors++; $display("FAIL single_rsp_data: got id %h count %h want 0 7", rsp_id_a, rsp_count_a); end
    vectors++; if (acc_total_a !== 16'd7) begin errors++; $display("FAIL single_acc: got %0d want 7", acc_total_a); end
    @(negedge clk);
    vectors++; if (rsp_valid_a !== 1'b0) begin errors++; $display("FAIL single_rsp_pulse_width: got %b want 0", rsp_valid_a); end
    vectors++; if (rsp_count_a !== 4'h7 || det_din_a !== 32'h7) begin errors++; $display("FAIL single_hold: got count %h din %h want 7 7", rsp_count_a, det_din_a); end
  endtask

  // Two requesters held valid: grants alternate, one response per 3 cycles.
  task automatic test_back_to_back();
    int g = 0, n = 0, cyc = 0, last = 0;
    do_reset();
    req_valid_a = 2'b11;
    req_data_a  = {32'h0000_0002, 32'h0000_0001};
    #1;
    while (n < 6 && cyc < 40) begin
      if (req_ready_a !== 2'b00) begin
        vectors++;
        if (req_ready_a !== ((g % 2) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL b2b_grant%0d: got %b want %b", g, req_ready_a, ((g % 2) ? 2'b10 : 2'b01)); end
        g++;
      end
      if (rsp_valid_a === 1'b1) begin
        vectors++;
        if (rsp_id_a !== 1'(n % 2) || rsp_count_a !== ((n % 2) ? 4'h2 : 4'h1)) begin errors++; $display("FAIL b2b_rsp%0d: got id %h count %h want %0d %0d", n, rsp_id_a, rsp_count_a, n % 2, (n % 2) ? 2 : 1); end
        if (n > 0) begin
          vectors++;
          if (cyc - last !== 3) begin errors++; $display("FAIL b2b_spacing%0d: got %0d cycles want 3", n, cyc - last); end
        end
        last = cyc;
        n++;
      end
      if (n < 6) begin
        @(negedge clk); #1; cyc++;
      end
    end
    vectors++; if (n !== 6) begin errors++; $display("FAIL b2b_timeout: got %0d responses want 6", n); end
    vectors++; if (acc_total_a !== 16'd9 || acc_sat_a !== 1'b0) begin errors++; $display("FAIL b2b_acc: got %0d/%b want 9/0", acc_total_a, acc_sat_a); end
    req_valid_a = 2'b00;
  endtask

  // Three requesters: pointer wraps at N_REQ, then rotates 2 -> 0 -> 2.
  task automatic test_wrap();
    logic [2:0] vld [3] = '{3'b100, 3'b101, 3'b101};
    logic [2:0] rdy [3] = '{3'b100, 3'b001, 3'b100};
    logic [1:0] id  [3] = '{2'd2,   2'd0,   2'd2};
    logic [3:0] cnt [3] = '{4'h3,   4'h5,   4'h3};
    do_reset();
    req_data_b = {32'h0000_0003, 32'h0000_0000, 32'h0000_0005};
    for (int s = 0; s < 3; s++) begin
      req_valid_b = vld[s];
      #1;
      vectors++; if (req_ready_b !== rdy[s]) begin errors++; $display("FAIL wrap_ready%0d: got %b want %b", s, req_ready_b, rdy[s]); end
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (rsp_valid_b === 1'b1) break;
      end
      vectors++; if (rsp_valid_b !== 1'b1) begin errors++; $display("FAIL wrap_timeout%0d: got rsp_valid %b want 1", s, rsp_valid_b); end
      vectors++; if (rsp_id_b !== id[s] || rsp_count_b !== cnt[s]) begin errors++; $display("FAIL wrap_rsp%0d: got id %0d count %h want %0d %h", s, rsp_id_b, rsp_count_b, id[s], cnt[s]); end
    end
    req_valid_b = 3'b000;
    vectors++; if (acc_total_b !== 4'd11 || acc_sat_b !== 1'b0) begin errors++; $display("FAIL wrap_acc: got %0d/%b want 11/0", acc_total_b, acc_sat_b); end
    acc_clear_b = 1'b1;
    @(negedge clk);
    acc_clear_b = 1'b0;
    vectors++; if (acc_total_b !== 4'd0) begin errors++; $display("FAIL idle_clear: got %0d want 0", acc_total_b); end
  endtask

  // 4-bit total saturates; a clear coinciding with RESP wins.
  task automatic test_saturate();
    do_reset();
    req_data_b  = {32'h0, 32'h0000_000F, 32'h0};
    req_valid_b = 3'b010;
    for (int s = 0; s < 2; s++) begin
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (rsp_valid_b === 1'b1) break;
      end
      vectors++; if (rsp_valid_b !== 1'b1 || rsp_count_b !== 4'hF) begin errors++; $display("FAIL sat_rsp%0d: got valid %b count %h want 1 f", s, rsp_valid_b, rsp_count_b); end
      vectors++; if (acc_total_b !== 4'hF || acc_sat_b !== 1'(s)) begin errors++; $display("FAIL sat_acc%0d: got %h/%b want f/%0d", s, acc_total_b, acc_sat_b, s); end
    end
    @(negedge clk);  // third transfer taken: DRIVE
    req_valid_b = 3'b000;
    @(negedge clk);  // RESP
    acc_clear_b = 1'b1;
    @(negedge clk);
    acc_clear_b = 1'b0;
    vectors++; if (rsp_valid_b !== 1'b1 || rsp_count_b !== 4'hF || rsp_id_b !== 2'd1) begin errors++; $display("FAIL clear_rsp: got valid %b count %h id %0d want 1 f 1", rsp_valid_b, rsp_count_b, rsp_id_b); end
    vectors++; if (acc_total_b !== 4'h0 || acc_sat_b !== 1'b0) begin errors++; $display("FAIL clear_wins: got %h/%b want 0/0", acc_total_b, acc_sat_b); end
    @(negedge clk);
    vectors++; if (acc_total_b !== 4'h0) begin errors++; $display("FAIL clear_late_add: got %h want 0", acc_total_b); end
  endtask

  // Asynchronous reset during DRIVE abandons the transaction.
  task automatic test_reset_mid();
    do_reset();
    req_valid_a = 2'b01;
    req_data_a  = {32'h0000_0006, 32'h0000_0009};
    @(negedge clk);  // DRIVE
    vectors++; if (det_din_a !== 32'h9) begin errors++; $display("FAIL mid_det_din: got %h want 9", det_din_a); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (det_din_a !== 32'h0 || req_ready_a !== 2'b00 || rsp_valid_a !== 1'b0) begin errors++; $display("FAIL mid_async_clear: got din %h ready %b rsp %b want 0 00 0", det_din_a, req_ready_a, rsp_valid_a); end
    req_valid_a = 2'b00;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      vectors++; if (rsp_valid_a !== 1'b0) begin errors++; $display("FAIL mid_no_rsp%0d: got %b want 0", c, rsp_valid_a); end
    end
    req_valid_a = 2'b11;
    #1;
    vectors++; if (req_ready_a !== 2'b01) begin errors++; $display("FAIL mid_ptr_reset: got %b want 01", req_ready_a); end
    req_valid_a = 2'b10;
    #1;
    vectors++; if (req_ready_a !== 2'b10) begin errors++; $display("FAIL mid_req1_ready: got %b want 10", req_ready_a); end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rsp_valid_a === 1'b1) break;
    end
    req_valid_a = 2'b00;
    vectors++; if (rsp_valid_a !== 1'b1 || rsp_id_a !== 1'b1 || rsp_count_a !== 4'h6) begin errors++; $display("FAIL mid_req1_rsp: got valid %b id %h count %h want 1 1 6", rsp_valid_a, rsp_id_a, rsp_count_a); end
    vectors++; if (acc_total_a !== 16'd6) begin errors++; $display("FAIL mid_acc: got %0d want 6", acc_total_a); end
  endtask

  initial begin
    rst_n = 1'b1;
    req_valid_a = '0; req_data_a = '0; acc_clear_a = 1'b0;
    req_valid_b = '0; req_data_b = '0; acc_clear_b = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_wrap();
    test_saturate();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/pattern_scan_arbiter.md
Name: pattern_scan_arbiter

Overview:
Shares one combinational pattern-detector instance (32-bit word in, 4-bit match count out) between N_REQ requesters. A round-robin arbiter selects one requester at a time and registers its word onto the detector input. The block then captures the count, returns it tagged with the requester ID, and keeps a saturating running total. It sits between the word producers and the single detect_pattern instance at the top level.

Parameters:
N_REQ, 2, number of requesters (>=2)
DW, 32, data word width, must match detector input
CW, 4, detector count width, must match detector output
ACC_W, 16, running-total width
IDW, $clog2(N_REQ), requester ID width (derived, not overridden)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  N_REQ  per-requester word valid
req_data  in  N_REQ*DW  packed words; requester i occupies bits [i*DW +: DW]
req_ready  out  N_REQ  one-hot grant/accept; transfer occurs when req_valid[i] & req_ready[i]
det_din  out  DW  registered word driven to the shared detector
det_count  in  CW  detector result (combinational from det_din)
rsp_valid  out  1  single-cycle result pulse
rsp_id  out  IDW  requester that owns rsp_count
rsp_count  out  CW  captured detector count
acc_clear  in  1  synchronous clear of acc_total and acc_sat
acc_total  out  ACC_W  saturating sum of all reported counts
acc_sat  out  1  sticky flag, set when the sum would exceed 2^ACC_W-1

Behaviour:
- Reset (async assert, sync release): state=IDLE, rr_ptr=0, det_din=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_count=0, acc_total=0, acc_sat=0.
- FSM states: IDLE -> DRIVE -> RESP -> IDLE. The transition IDLE->DRIVE happens only on a transfer.
- IDLE:
  - req_ready is combinational, only in IDLE, and at most one bit is high.
  - The granted requester is the first i with req_valid[i]=1, searching from rr_ptr upward with wrap-around.
  - On transfer: det_din <= granted word, gnt_id <= i, rr_ptr <= (i+1) mod N_REQ.
  - With no valid request: req_ready=0 and rr_ptr is unchanged.
- DRIVE: one settle cycle for the detector. req_ready=0. Go to RESP.
- RESP:
  - rsp_count <= det_count, rsp_id <= gnt_id, rsp_valid=1 for exactly this one cycle.
  - Accumulator is updated (rules below). Return to IDLE.
- Latency and throughput:
  - Transfer at edge T; det_din valid after T; rsp_valid high in the cycle after edge T+2.
  - Maximum throughput is one word per 3 cycles.
  - There is no response backpressure.
- Requester protocol: hold req_valid and req_data stable until accepted. Deasserting req_valid before acceptance is allowed; the request is simply dropped from arbitration.
- det_din holds its last value outside transfers. rsp_id and rsp_count hold their values after the pulse.
- Accumulator:
  - Update in RESP: sum = acc_total + det_count at ACC_W+1 bits.
  - If sum > 2^ACC_W-1: acc_total = all-ones, acc_sat = 1.
  - Once saturated, acc_total stays all-ones until cleared.
- acc_clear:
  - Any state: acc_total <= 0, acc_sat <= 0.
  - If acc_clear coincides with RESP, the clear wins and that count is not added. rsp_valid and rsp_count are still produced.
- Reset mid-transaction (DRIVE or RESP): the transaction is abandoned, no rsp_valid is produced, and the ptr returns to 0.
- With N_REQ not a power of 2, rr_ptr wraps at N_REQ, never at 2^IDW.

Test Plan:
1. Bench stub det_count = det_din[3:0]. Req0 only, word 0x0000_0007, transfer at edge 1 -> rsp_valid exactly one cycle after edge 3, rsp_id=0, rsp_count=7, acc_total=7, req_ready=0 during DRIVE and RESP.
2. Req0 and req1 both held valid continuously, words 0x1 and 0x2, for 6 transactions -> grants alternate 0,1,0,1,0,1; rsp_count alternates 1,2; acc_total=9; one response every 3 cycles.
3. N_REQ=3, only req2 valid, then req0 and req2 valid -> first grant 2, ptr wraps to 0, next grant 0, then 2.
4. ACC_W=4, stub count fixed at 15, two transactions -> acc_total=15, acc_sat=1. Pulse acc_clear in the second RESP cycle -> acc_total=0, acc_sat=0, rsp_count=15 still reported.
5. Assert rst_n=0 asynchronously mid-DRIVE -> all outputs zero immediately, no rsp_valid afterward. After release, req1 alone granted with ptr=0 search, response correct.
6. With the real detect_pattern instance, words 0xFFFF_FFFF then 0x0000_0004 -> rsp_count 0 then 1, acc_total=1.
